spi_slave_sample_port: RTL and testbench

SPI responder (slave) that streams buffered ADC samples out of the FPGA to an external microcontroller acting as SPI master. It is the counterpart of the ADC SPI master: the FPGA answers transfers instead of initiating them. The block sits between the sample FIFO (show-ahead read side) and the MBED GPIO header. SCK, CSbar and MOSI are oversampled in the CLK_FAST domain. Each completed 16-bit transfer pops one FIFO word and captures one command word from the master.

---
 rtl/spi_slave_sample_port_if.sv | 30 +++
 rtl/spi_slave_sample_port.sv | 159 +++++++++++++++
 tb/tb_spi_slave_sample_port.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_sample_port_if.sv
// SPI pins plus FIFO read side and RX/status strobes of the sample port.
// Handshake semantics: TX_RDREQ is a one-cycle pop of the show-ahead FIFO.
// RX_VALID, FIN and ABORT are one-cycle strobes. No back-pressure exists on any of them.
interface spi_slave_sample_port_if #(
  parameter int WORD_BITS = 16
);
  logic                 SCK;
  logic                 CSbar;
  logic                 MOSI;
  logic                 MISO;
  logic                 MISO_OE;
  logic [WORD_BITS-1:0] TX_DATA;
  logic                 TX_EMPTY;
  logic                 TX_RDREQ;
  logic [WORD_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 FIN;
  logic                 ABORT;
  logic                 BUSY;

  modport slave (
    input  SCK, CSbar, MOSI, TX_DATA, TX_EMPTY,
    output MISO, MISO_OE, TX_RDREQ, RX_DATA, RX_VALID, FIN, ABORT, BUSY
  );

  modport master (
    output SCK, CSbar, MOSI, TX_DATA, TX_EMPTY,
    input  MISO, MISO_OE, TX_RDREQ, RX_DATA, RX_VALID, FIN, ABORT, BUSY
  );
endinterface

// File: rtl/spi_slave_sample_port.sv
// Mode-0 SPI responder: shifts FIFO words out on MISO and captures one
// command word per frame. SPI pins are oversampled in the CLK_FAST domain.
module spi_slave_sample_port #(
  parameter int               WORD_BITS   = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WORD_BITS-1:0] EMPTY_CODE = 16'h8000
) (
  input  logic                    CLK_FAST,
  input  logic                    RST,
  input  logic                    ENA,
  spi_slave_sample_port_if.slave  bus,
  output logic [1:0]              STATE_DBG
);
  localparam int CW = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WORD_BITS - 1);
  localparam logic [CW-1:0] WORD_CNT  = CW'(WORD_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
  logic                   sck_d, cs_d;
  logic                   sck_sync, cs_sync, mosi_sync;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  logic [WORD_BITS-1:0]   tx_shift, rx_shift, rx_data_q;
  logic [CW-1:0]          bitcnt;
  logic                   have_word, done_first;
  logic                   miso_q, miso_oe_q, rdreq_q, rx_valid_q, fin_q, abort_q;

  // CSbar chain resets high so a deasserted chip select is never seen as a fall.
  always_ff @(posedge CLK_FAST) begin
    if (RST) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], bus.SCK};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.CSbar};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.MOSI};
      sck_d  <= sck_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sck_sync  = sck_q[SYNC_STAGES-1];
  assign cs_sync   = cs_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_q[SYNC_STAGES-1];
  assign sck_rise  = sck_sync & ~sck_d;
  assign sck_fall  = ~sck_sync & sck_d;
  assign cs_fall   = ~cs_sync & cs_d;
  assign cs_rise   = cs_sync & ~cs_d;

  always_ff @(posedge CLK_FAST) begin
    if (RST) miso_oe_q <= 1'b0;
    else     miso_oe_q <= ENA & ~cs_sync;
  end

  always_ff @(posedge CLK_FAST) begin
    if (RST) begin
      state      <= ST_IDLE;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      bitcnt     <= '0;
      have_word  <= 1'b0;
      done_first <= 1'b0;
      miso_q     <= 1'b0;
      rdreq_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      fin_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rdreq_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      fin_q      <= 1'b0;
      abort_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso_q     <= 1'b0;
          done_first <= 1'b0;
          if (cs_fall && ENA) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!ENA || cs_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            if (!bus.TX_EMPTY) begin
              tx_shift  <= bus.TX_DATA;
              have_word <= 1'b1;
              miso_q    <= bus.TX_DATA[WORD_BITS-1];
            end else begin
              tx_shift  <= EMPTY_CODE;
              have_word <= 1'b0;
              miso_q    <= EMPTY_CODE[WORD_BITS-1];
            end
            bitcnt <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A final rising edge wins over a coincident CSbar rise.
          if (!ENA) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state   <= ST_IDLE;
          end else if (sck_rise && bitcnt == LAST_BIT) begin
            rx_shift   <= {rx_shift[WORD_BITS-2:0], mosi_sync};
            bitcnt     <= bitcnt + 1'b1;
            done_first <= 1'b1;
            state      <= ST_DONE;
          end else if (cs_rise) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            state   <= ST_IDLE;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[WORD_BITS-2:0], mosi_sync};
            bitcnt   <= bitcnt + 1'b1;
          end else if (sck_fall && bitcnt < WORD_CNT) begin
            tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
            miso_q   <= tx_shift[WORD_BITS-2];
          end
        end
        ST_DONE: begin
          miso_q <= 1'b0;
          if (done_first) begin
            rx_data_q  <= rx_shift;
            rx_valid_q <= 1'b1;
            fin_q      <= 1'b1;
            rdreq_q    <= have_word;
            done_first <= 1'b0;
          end
          if (cs_sync || !ENA) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.MISO_OE  = miso_oe_q;
  assign bus.TX_RDREQ = rdreq_q;
  assign bus.RX_DATA  = rx_data_q;
  assign bus.RX_VALID = rx_valid_q;
  assign bus.FIN      = fin_q;
  assign bus.ABORT    = abort_q;
  assign bus.BUSY     = (state != ST_IDLE);
  assign STATE_DBG    = state;
endmodule

// File: tb/tb_spi_slave_sample_port.sv
// Directed bench: a mode-0 SPI master at CLK_FAST/8 plus a small FIFO model.
module tb_spi_slave_sample_port;
  logic CLK_FAST = 1'b0;
  logic RST = 1'b1;
  logic ENA = 1'b1;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  logic [15:0] fifo_mem [32];
  int wr_cnt = 0;
  int rd_ptr = 0;
  int fin_cnt = 0, rxv_cnt = 0, rdreq_cnt = 0, abort_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  spi_slave_sample_port_if #(.WORD_BITS(16)) bus ();

  spi_slave_sample_port #(.WORD_BITS(16), .SYNC_STAGES(2), .EMPTY_CODE(16'h8000)) dut (
    .CLK_FAST  (CLK_FAST),
    .RST       (RST),
    .ENA       (ENA),
    .bus       (bus),
    .STATE_DBG (state_dbg)
  );

  always #5 CLK_FAST = ~CLK_FAST;

  assign bus.TX_DATA  = fifo_mem[rd_ptr[4:0]];
  assign bus.TX_EMPTY = (rd_ptr >= wr_cnt);

  // Monitor: strobe counters and FIFO pops, sampled away from the active edge.
  always @(negedge CLK_FAST) begin
    if (!RST && bus.TX_RDREQ) rd_ptr <= rd_ptr + 1;
    if (bus.FIN)      fin_cnt   <= fin_cnt + 1;
    if (bus.RX_VALID) rxv_cnt   <= rxv_cnt + 1;
    if (bus.TX_RDREQ) rdreq_cnt <= rdreq_cnt + 1;
    if (bus.ABORT)    abort_cnt <= abort_cnt + 1;
    if (bus.MISO_OE)  oe_cnt    <= oe_cnt + 1;
    if (bus.BUSY)     busy_cnt  <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK_FAST);
  endtask

  task automatic sck_bit(input logic mosi_b, output logic miso_b);
    bus.MOSI = mosi_b;
    cycles(4);
    miso_b = bus.MISO;
    bus.SCK = 1'b1;
    cycles(4);
    bus.SCK = 1'b0;
  endtask

  task automatic cs_low();
    bus.CSbar = 1'b0;
    cycles(10);
  endtask

  task automatic cs_high(input int hold);
    cycles(4);
    bus.CSbar = 1'b1;
    cycles(hold);
  endtask

  task automatic shift_bits(input logic [31:0] mosi_w, input int nbits, output logic [31:0] miso_w);
    logic b;
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      sck_bit(mosi_w[nbits-1-i], b);
      miso_w = {miso_w[30:0], b};
    end
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_cnt[4:0]] = w;
    wr_cnt++;
  endtask

  initial begin
    logic [31:0] rd;
    int f0, v0, r0, a0, o0, b0;
    bus.SCK = 1'b0;
    bus.CSbar = 1'b1;
    bus.MOSI = 1'b0;
    for (int i = 0; i < 32; i++) fifo_mem[i] = 16'h0;
    cycles(4);
    RST = 1'b0;
    cycles(3);

    check("rst_miso", {31'd0, bus.MISO}, 32'd0);
    check("rst_miso_oe", {31'd0, bus.MISO_OE}, 32'd0);
    check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("rst_rx_data", {16'd0, bus.RX_DATA}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_strobes", fin_cnt + rxv_cnt + rdreq_cnt + abort_cnt, 32'd0);

    // Basic transfer.
    push(16'h0ABC);
    cs_low();
    check("t1_oe", {31'd0, bus.MISO_OE}, 32'd1);
    check("t1_busy", {31'd0, bus.BUSY}, 32'd1);
    shift_bits(32'h1234, 16, rd);
    cs_high(6);
    check("t1_miso_word", rd, 32'h0ABC);
    check("t1_rx_data", {16'd0, bus.RX_DATA}, 32'h1234);
    check("t1_rx_valid", rxv_cnt, 32'd1);
    check("t1_fin", fin_cnt, 32'd1);
    check("t1_rdreq", rdreq_cnt, 32'd1);
    check("t1_abort", abort_cnt, 32'd0);
    check("t1_idle", {31'd0, bus.BUSY}, 32'd0);

    // Empty FIFO at transfer start.
    cs_low();
    shift_bits(32'hA5A5, 16, rd);
    cs_high(6);
    check("t2_miso_word", rd, 32'h8000);
    check("t2_fin", fin_cnt, 32'd2);
    check("t2_rdreq", rdreq_cnt, 32'd1);
    check("t2_rx_data", {16'd0, bus.RX_DATA}, 32'hA5A5);

    // Abort after 9 rising edges, then retry.
    push(16'h0055);
    cs_low();
    shift_bits(32'h1FF, 9, rd);
    cs_high(6);
    check("t3_abort", abort_cnt, 32'd1);
    check("t3_fin", fin_cnt, 32'd2);
    check("t3_rx_valid", rxv_cnt, 32'd2);
    check("t3_rdreq", rdreq_cnt, 32'd1);
    check("t3_rx_data", {16'd0, bus.RX_DATA}, 32'hA5A5);
    cs_low();
    shift_bits(32'h0F0F, 16, rd);
    cs_high(6);
    check("t3_retry_word", rd, 32'h0055);
    check("t3_retry_rdreq", rdreq_cnt, 32'd2);
    check("t3_retry_rx", {16'd0, bus.RX_DATA}, 32'h0F0F);

    // Back-to-back frames at minimum CSbar high time.
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    for (int k = 1; k <= 3; k++) begin
      cs_low();
      shift_bits(32'h0100 + k, 16, rd);
      cs_high(4);
      check($sformatf("t4_word%0d", k), rd, k);
      check($sformatf("t4_rx%0d", k), {16'd0, bus.RX_DATA}, 32'h0100 + k);
    end
    cycles(4);
    check("t4_rdreq", rdreq_cnt, 32'd5);
    check("t4_fin", fin_cnt, 32'd6);

    // 20 SCK pulses in one frame: only 16 used, MISO low afterwards.
    push(16'hBEEF);
    cs_low();
    shift_bits(32'h12345, 20, rd);
    cs_high(6);
    check("t5_miso_20", rd, 32'hBEEF0);
    check("t5_rx_data", {16'd0, bus.RX_DATA}, 32'h1234);
    check("t5_fin", fin_cnt, 32'd7);
    check("t5_rdreq", rdreq_cnt, 32'd6);

    // Reset mid-transfer, then ENA low with chip select toggling.
    push(16'h7777);
    f0 = fin_cnt; v0 = rxv_cnt; r0 = rdreq_cnt; a0 = abort_cnt;
    cs_low();
    shift_bits(32'hFF, 8, rd);
    RST = 1'b1;
    ENA = 1'b0;
    bus.CSbar = 1'b1;
    cycles(3);
    RST = 1'b0;
    cycles(3);
    check("t6_miso", {31'd0, bus.MISO}, 32'd0);
    check("t6_oe", {31'd0, bus.MISO_OE}, 32'd0);
    check("t6_busy", {31'd0, bus.BUSY}, 32'd0);
    check("t6_rx_data", {16'd0, bus.RX_DATA}, 32'd0);
    o0 = oe_cnt; b0 = busy_cnt;
    for (int k = 0; k < 3; k++) begin
      cs_low();
      shift_bits(32'hAAAA, 16, rd);
      cs_high(6);
    end
    check("t6_oe_cnt", oe_cnt - o0, 32'd0);
    check("t6_busy_cnt", busy_cnt - b0, 32'd0);
    check("t6_strobes", (fin_cnt - f0) + (rxv_cnt - v0) + (rdreq_cnt - r0) + (abort_cnt - a0), 32'd0);
    check("t6_rx_data_hold", {16'd0, bus.RX_DATA}, 32'd0);

    // ENA dropped mid-transfer behaves as an abort; head word is retained.
    ENA = 1'b1;
    cycles(4);
    cs_low();
    shift_bits(32'h1F, 5, rd);
    ENA = 1'b0;
    cycles(4);
    check("t7_abort", abort_cnt - a0, 32'd1);
    check("t7_busy", {31'd0, bus.BUSY}, 32'd0);
    cs_high(6);
    ENA = 1'b1;
    cycles(4);
    cs_low();
    shift_bits(32'hC3C3, 16, rd);
    cs_high(6);
    check("t7_retry_word", rd, 32'h7777);
    check("t7_retry_rdreq", rdreq_cnt - r0, 32'd1);
    check("t7_retry_rx", {16'd0, bus.RX_DATA}, 32'hC3C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
